// File: rtl/bcd_field_counter_pkg.sv
// clock_pkg: shared BCD types and binary/BCD conversion for the clock time fields
package clock_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;
  localparam int MAX_BCD_VAL = 99;
  function automatic bcd_pair_t bin_to_bcd(input logic [6:0] b);
    return {bcd_digit_t'(b / 7'd10), bcd_digit_t'(b % 7'd10)};
  endfunction
  function automatic logic [6:0] bcd_to_bin(input bcd_pair_t d);
    return 7'(d[7:4]) * 7'd10 + 7'(d[3:0]);
  endfunction
endpackage

// File: rtl/bcd_field_counter_if.sv
// bcd_field_counter_if: count/adjust controls and BCD field outputs of one time field
interface bcd_field_counter_if;
  import clock_pkg::*;
  logic tick;
  logic set_ena;
  logic up;
  logic down;
  bcd_pair_t bcd_out;
  logic tc;
  logic at_max;
  modport master (output tick, set_ena, up, down, input bcd_out, tc, at_max);
  modport slave (input tick, set_ena, up, down, output bcd_out, tc, at_max);
endinterface

// File: rtl/bcd_field_counter_key_repeat.sv
// key_repeat: key rising-edge detector, with hold/auto-repeat timer when AUTO_REPEAT_EN is defined
module key_repeat #(
  parameter int DLY = 8,
  parameter int PER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  input  logic i_en,
  output logic o_step
);
  logic r_key;
  logic w_edge;
  if (DLY < 2 || PER < 1) begin : g_bad_params
    $error("key_repeat: DLY must be >= 2 and PER >= 1");
  end
  assign w_edge = i_key & ~r_key;
  // edge register tracks the key in every mode so a key held into set mode never counts as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_key <= 1'b0;
    else r_key <= i_key;
  end
`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(DLY + PER + 1);
  logic [CW-1:0] r_cnt;
  logic r_arm;
  logic r_rep;
  logic w_fire;
  assign w_fire = r_arm & i_key & i_en & (r_cnt == (r_rep ? CW'(PER) : CW'(DLY)));
  assign o_step = (i_en & w_edge) | w_fire;
  // armed only by a press seen in set mode; r_rep selects the initial delay or the repeat period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_arm <= 1'b0;
      r_rep <= 1'b0;
    end else if (!i_key || !i_en) begin
      r_cnt <= '0;
      r_arm <= 1'b0;
      r_rep <= 1'b0;
    end else if (w_edge || w_fire) begin
      r_cnt <= CW'(1);
      r_arm <= 1'b1;
      r_rep <= w_fire;
    end else if (r_arm) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign o_step = i_en & w_edge;
`endif
endmodule

// File: rtl/bcd_field_counter.sv
// bcd_field_counter: 2-digit BCD time field counter with carry and set-mode adjust (AUTO_REPEAT_EN enables key repeat)
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter int MODULUS    = 24,
  parameter int MIN_VAL    = 0,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4
) (
  input logic clk,
  input logic rst,
  bcd_field_counter_if.slave s_if
);
  localparam logic [6:0] MIN_V = 7'(MIN_VAL);
  localparam logic [6:0] MAX_V = 7'(MIN_VAL + MODULUS - 1);
  if (MODULUS < 2 || MODULUS > MAX_BCD_VAL || MIN_VAL < 0 || MIN_VAL + MODULUS - 1 > MAX_BCD_VAL) begin : g_bad_params
    $error("bcd_field_counter: MODULUS/MIN_VAL out of range");
  end
  logic [6:0] r_val;
  logic r_tc;
  logic w_up;
  logic w_dn;
  logic w_run;
  logic w_inc;
  logic w_dec;
  logic w_at_max;
  key_repeat #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_up (
    .clk(clk), .rst(rst), .i_key(s_if.up), .i_en(s_if.set_ena), .o_step(w_up)
  );
  key_repeat #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_dn (
    .clk(clk), .rst(rst), .i_key(s_if.down), .i_en(s_if.set_ena), .o_step(w_dn)
  );
  // a step of one key is cancelled while the other key is held
  always_comb begin
    w_run    = s_if.tick & ~s_if.set_ena;
    w_at_max = r_val == MAX_V;
    w_inc    = w_run | (w_up & ~s_if.down);
    w_dec    = w_dn & ~s_if.up;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= MIN_V;
      r_tc  <= 1'b0;
    end else begin
      r_tc <= w_run & w_at_max;
      if (w_inc) r_val <= w_at_max ? MIN_V : r_val + 7'd1;
      else if (w_dec) r_val <= (r_val == MIN_V) ? MAX_V : r_val - 7'd1;
    end
  end
  assign s_if.bcd_out = bin_to_bcd(r_val);
  assign s_if.tc      = r_tc;
  assign s_if.at_max  = w_at_max;
endmodule
